disp4_scan: RTL and testbench
=============================

DISP4_SCAN -- requirements
Module: disp4_scan

Interface
REQ-001 The block SHALL provide parameter DIV, default 50000, giving the number of enabled clk cycles each digit stays selected (legal range 2..2^20).
REQ-002 The block SHALL provide parameter LZB, default 1, enabling leading-zero blanking when 1.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all state updates on its rising edge.
REQ-005 R  in  1  synchronous active-high reset.
REQ-006 ce  in  1  scan enable; 0 freezes prescaler and scan index.
REQ-007 ld  in  1  load strobe; samples dat/dp into shadow registers (typically driven by the counter chain CEO or a 1 Hz tick).
REQ-008 dat  in  16  four hex digits from cascaded 4-bit counters; dat[3:0] = digit 0 (rightmost), dat[15:12] = digit 3.
REQ-009 dp  in  4  decimal point per digit, 1 = lit; dp[0] = digit 0.
REQ-010 AN  out  4  digit anodes, active-low, one-hot-low when lit.
REQ-011 SEG  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 DP  out  1  decimal point of selected digit, active-low.
REQ-013 TC_SCAN  out  1  one-cycle pulse when scan index wraps 3 -> 0.

Function
REQ-014 Prescaler SHALL count 0..DIV-1 on cycles with ce=1, hold when ce=0, and generate internal tick on the cycle where count==DIV-1 and ce=1, returning to 0 on the next edge.
REQ-015 On tick the 2-bit scan index SHALL advance 0->1->2->3->0; TC_SCAN SHALL be 1 in the cycle following the 3->0 advance only.
REQ-016 When ld=1 the shadow registers SHALL load dat and dp on that edge; displayed data changes only via ld, never directly from dat.
REQ-017 ld and tick in the same cycle SHALL both take effect; the newly selected digit shows the newly loaded data.
REQ-018 AN, SEG, DP SHALL be registered and reflect (scan index, shadow data) with exactly 1 cycle latency.
REQ-019 AN bit k SHALL be 0 only when index==k and digit k is not blanked; all other bits 1.
REQ-020 SEG SHALL be the standard hex decode 0-F (A,b,C,d,E,F), active-low; a blanked digit SHALL output SEG=7'h7F and DP=1.
REQ-021 With LZB=1, digit k (k=3..1) SHALL be blanked if shadow digits k..3 are all zero and dp[k..3] all zero; digit 0 SHALL never be blanked; with LZB=0 no digit is blanked.
REQ-022 DP SHALL be ~dp_shadow[index] for an unblanked digit.

Reset
REQ-023 R=1 SHALL have priority over ce and ld and, on that edge, set prescaler=0, index=0, shadow dat=0, shadow dp=0, AN=4'b1111, SEG=7'h7F, DP=1, TC_SCAN=0.
REQ-024 Reset mid-scan SHALL abandon the current period; the first cycle after R deasserts SHALL drive AN=4'b1110 showing "0" (SEG=7'h40) on the following edge.

Structure
REQ-025 Segment constants (hex 0-F patterns, blank pattern 7'h7F, AN_OFF 4'b1111) SHALL live in the shared display package.
REQ-026 Hex-to-segment decode SHALL be a combinational sub-module hex7seg (4-bit in, 7-bit active-low out); prescaler, scan index, shadow and blanking logic stay in disp4_scan.

Verification (DIV=4)
REQ-027 R=1 two cycles, then ce=1, ld=0 -> AN sequence 1110,1101,1011,0111 each held 4 cycles with digits 1..3 blanked (AN stays 1111 for them), digit0 SEG=7'h40; TC_SCAN pulses once per 16 cycles.
REQ-028 ld=1 with dat=16'h12AF, dp=4'b0100 -> digits show F,A,2,1 (SEG 7'h0E,7'h08,7'h24,7'h79); DP=0 only while AN=1011.
REQ-029 LZB=1, dat=16'h0050, dp=0 -> digit3,2 blanked (AN never 0111/1011), digit1 "5" (7'h12), digit0 "0"; same with dp=4'b1000 -> digit3 lit "0" with DP=0, digit2 lit "0".
REQ-030 ce=0 for 10 cycles mid-digit 2 -> AN stays 1011, prescaler resumes from held count, digit 2 total dwell = 4 enabled cycles.
REQ-031 ld coincident with tick, dat changing every cycle while ld=0 -> display shows only ld-sampled values; new value visible on the newly selected digit one cycle after the edge.
REQ-032 R=1 asserted while index=3 -> next cycle AN=1111, SEG=7'h7F, TC_SCAN=0; scan restarts at digit 0 with full DIV dwell.

Source files
------------

// File: rtl/disp4_scan_pkg.sv
// Shared constants and helpers for the 4-digit multiplexed 7-segment scanner.
package disp4_scan_pkg;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Active-low {g,f,e,d,c,b,a} patterns; entry 15 first so HEX_SEG[n] decodes n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // A digit blanks only if it and every digit to its left are zero with no dp lit.
  function automatic logic [3:0] blank_mask(input logic [15:0] d,
                                            input logic [3:0]  p,
                                            input logic        lzb);
    logic [3:0] m;
    logic       run;
    m   = '0;
    run = lzb;
    for (int unsigned i = 3; i >= 1; i--) begin
      run  = run && (d[4*i +: 4] == 4'h0) && !p[i];
      m[i] = run;
    end
    return m;
  endfunction

endpackage

// File: rtl/disp4_scan_if.sv
// Data/control bundle between a counter chain and the display scanner.
interface disp4_scan_if;
  logic        ce;
  logic        ld;
  logic [15:0] dat;
  logic [3:0]  dp;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic        TC_SCAN;

  modport master (
    output ce, ld, dat, dp,
    input  AN, SEG, DP, TC_SCAN
  );

  modport slave (
    input  ce, ld, dat, dp,
    output AN, SEG, DP, TC_SCAN
  );
endinterface

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low 7-segment decode.
module hex7seg
  import disp4_scan_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = HEX_SEG[hex_i];
  end

endmodule

// File: rtl/disp4_scan.sv
// Four-digit multiplexed 7-segment driver: prescaled scan, shadowed data,
// optional leading-zero blanking, registered active-low outputs.
module disp4_scan
  import disp4_scan_pkg::*;
#(
  parameter int unsigned DIV = 50000,
  parameter bit          LZB = 1'b1
) (
  input  logic          clk,
  input  logic          R,
  disp4_scan_if.slave   bus
);

  localparam int unsigned CW = $clog2(DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  digit_e        idx_q, idx_d;
  logic [15:0]   dat_q, dat_d;
  logic [3:0]    dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dpo_q, dpo_d;
  logic          tc_q, tc_d;

  logic          tick;
  logic [3:0]    blank;
  logic [3:0]    nib;
  logic [6:0]    seg_raw;

  hex7seg u_hex7seg (
    .hex_i (nib),
    .seg_o (seg_raw)
  );

  always_comb begin
    tick  = bus.ce && (cnt_q == CW'(DIV - 1));
    cnt_d = cnt_q;
    if (bus.ce) cnt_d = tick ? '0 : cnt_q + CW'(1);
    idx_d = tick ? digit_e'(idx_q + 2'd1) : idx_q;
    dat_d = bus.ld ? bus.dat : dat_q;
    dp_d  = bus.ld ? bus.dp  : dp_q;
    tc_d  = tick && (idx_q == DIG3);
  end

  // Outputs follow the current index/shadow, so a same-edge ld+tick shows new data next cycle.
  always_comb begin
    nib   = dat_q[idx_q*4 +: 4];
    blank = blank_mask(dat_q, dp_q, LZB);
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dpo_d = 1'b1;
    if (!blank[idx_q]) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = seg_raw;
      dpo_d = ~dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      cnt_q <= '0;
      idx_q <= DIG0;
      dat_q <= '0;
      dp_q  <= '0;
      an_q  <= AN_OFF;
      seg_q <= SEG_BLANK;
      dpo_q <= 1'b1;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      dat_q <= dat_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dpo_q <= dpo_d;
      tc_q  <= tc_d;
    end
  end

  assign bus.AN      = an_q;
  assign bus.SEG     = seg_q;
  assign bus.DP      = dpo_q;
  assign bus.TC_SCAN = tc_q;

endmodule

// File: tb/tb_disp4_scan.sv
// Directed bench for disp4_scan with DIV=4; a second instance with LZB=0 shares stimulus.
module tb_disp4_scan;

  logic clk = 1'b0;
  logic R;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  disp4_scan_if ifa ();
  disp4_scan_if ifb ();

  assign ifb.ce  = ifa.ce;
  assign ifb.ld  = ifa.ld;
  assign ifb.dat = ifa.dat;
  assign ifb.dp  = ifa.dp;

  disp4_scan #(.DIV(4), .LZB(1'b1)) dut (
    .clk (clk),
    .R   (R),
    .bus (ifa.slave)
  );

  disp4_scan #(.DIV(4), .LZB(1'b0)) dut_b (
    .clk (clk),
    .R   (R),
    .bus (ifb.slave)
  );

  // Expected words are {AN, SEG, DP, TC_SCAN}.
  localparam logic [12:0] OFF  = {4'b1111, 7'h7F, 1'b1, 1'b0};
  localparam logic [12:0] D0Z  = {4'b1110, 7'h40, 1'b1, 1'b0};
  localparam logic [12:0] D0F  = {4'b1110, 7'h0E, 1'b1, 1'b0};
  localparam logic [12:0] D1A  = {4'b1101, 7'h08, 1'b1, 1'b0};
  localparam logic [12:0] D2_2 = {4'b1011, 7'h24, 1'b0, 1'b0};
  localparam logic [12:0] D3_1 = {4'b0111, 7'h79, 1'b1, 1'b0};
  localparam logic [12:0] D1_5 = {4'b1101, 7'h12, 1'b1, 1'b0};
  localparam logic [12:0] D2Z  = {4'b1011, 7'h40, 1'b1, 1'b0};
  localparam logic [12:0] D3Z  = {4'b0111, 7'h40, 1'b1, 1'b0};
  localparam logic [12:0] D3ZP = {4'b0111, 7'h40, 1'b0, 1'b0};
  localparam logic [12:0] D0C  = {4'b1110, 7'h46, 1'b1, 1'b0};
  localparam logic [12:0] D1_7 = {4'b1101, 7'h78, 1'b1, 1'b0};
  localparam logic [12:0] D2B  = {4'b1011, 7'h03, 1'b1, 1'b0};
  localparam logic [12:0] D3_5 = {4'b0111, 7'h12, 1'b1, 1'b0};
  localparam logic [12:0] TC   = 13'd1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n cycles checking every cycle; optionally check the LZB=0 instance
  // and scramble dat before each edge.
  task automatic hold(input string tag, input int n, input logic [12:0] ea,
                      input bit use_b = 1'b0, input logic [12:0] eb = '0,
                      input bit scr = 1'b0);
    for (int i = 0; i < n; i++) begin
      if (scr) ifa.dat = 16'($urandom);
      step();
      chk(tag, {ifa.AN, ifa.SEG, ifa.DP, ifa.TC_SCAN}, ea);
      if (use_b) chk({tag, "_nolzb"}, {ifb.AN, ifb.SEG, ifb.DP, ifb.TC_SCAN}, eb);
    end
  endtask

  initial begin
    R       = 1'b1;
    ifa.ce  = 1'b0;
    ifa.ld  = 1'b0;
    ifa.dat = '0;
    ifa.dp  = '0;

    step();
    hold("reset", 1, OFF, 1'b1, OFF);
    R      = 1'b0;
    ifa.ce = 1'b1;

    // Idle scan of all-zero shadow: only digit 0 lights.
    for (int r = 0; r < 2; r++) begin
      hold("p1_d0", 4, D0Z);
      hold("p1_blank", 11, OFF);
      hold("p1_wrap", 1, OFF | TC);
    end

    ifa.ld = 1'b1; ifa.dat = 16'h12AF; ifa.dp = 4'b0100;
    hold("p2_ldlat", 1, D0Z);
    ifa.ld = 1'b0;
    hold("p2_d0", 3, D0F);
    hold("p2_d1", 4, D1A);
    hold("p2_d2", 4, D2_2);
    hold("p2_d3", 3, D3_1);
    hold("p2_wrap", 1, D3_1 | TC);

    ifa.ld = 1'b1; ifa.dat = 16'h0050; ifa.dp = 4'b0000;
    hold("p3_ldlat", 1, D0F);
    ifa.ld = 1'b0;
    hold("p3_d0", 3, D0Z);
    hold("p3_d1", 4, D1_5, 1'b1, D1_5);
    hold("p3_d2", 4, OFF, 1'b1, D2Z);
    hold("p3_d3", 3, OFF, 1'b1, D3Z);
    hold("p3_wrap", 1, OFF | TC, 1'b1, D3Z | TC);

    ifa.ld = 1'b1; ifa.dp = 4'b1000;
    hold("p3b_ldlat", 1, D0Z);
    ifa.ld = 1'b0;
    hold("p3b_d0", 3, D0Z);
    hold("p3b_d1", 4, D1_5);
    hold("p3b_d2", 4, D2Z);
    hold("p3b_d3", 3, D3ZP);
    hold("p3b_wrap", 1, D3ZP | TC);

    // Freeze the scan mid-digit 2; total enabled dwell must stay 4.
    ifa.ld = 1'b1; ifa.dat = 16'h12AF; ifa.dp = 4'b0100;
    hold("p4_ldlat", 1, D0Z);
    ifa.ld = 1'b0;
    hold("p4_d0", 3, D0F);
    hold("p4_d1", 4, D1A);
    hold("p4_d2pre", 2, D2_2);
    ifa.ce = 1'b0;
    hold("p4_frozen", 10, D2_2);
    ifa.ce = 1'b1;
    hold("p4_d2post", 2, D2_2);
    hold("p4_d3", 3, D3_1);
    hold("p4_wrap", 1, D3_1 | TC);

    // dat wiggles without ld; then ld lands on the tick edge.
    hold("p5_noload", 3, D0F, 1'b0, '0, 1'b1);
    ifa.ld = 1'b1; ifa.dat = 16'h5B7C; ifa.dp = 4'b0000;
    hold("p5_ldtick", 1, D0F);
    ifa.ld = 1'b0;
    hold("p5_d1", 4, D1_7, 1'b0, '0, 1'b1);
    hold("p5_d2", 4, D2B, 1'b0, '0, 1'b1);
    hold("p5_d3", 3, D3_5, 1'b0, '0, 1'b1);
    hold("p5_wrap", 1, D3_5 | TC, 1'b0, '0, 1'b1);

    // Reset while digit 3 is selected, with ld/ce asserted alongside.
    hold("p6_d0", 4, D0C);
    hold("p6_d1", 4, D1_7);
    hold("p6_d2", 4, D2B);
    hold("p6_d3", 2, D3_5);
    R = 1'b1; ifa.ld = 1'b1; ifa.dat = 16'hFFFF; ifa.dp = 4'b1111;
    hold("p6_reset", 1, OFF, 1'b1, OFF);
    R = 1'b0; ifa.ld = 1'b0;
    hold("p6_restart", 4, D0Z);
    hold("p6_next", 1, OFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
